// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-master round-robin arbiter for the 4-bank byte-lane data SRAM
//
// Shares the 4x(512x8) data SRAM macros between the core data port (master 0)
// and a loader/debug master (master 1). One access per cycle, fully pipelined.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, we         per-master request and write flag (fields held until gnt)
//   addr, wdata     per-master byte address and write data (lane i = bits 8i+7:8i)
//   wmask           per-master byte enables for writes
//   gnt             one-hot grant, combinational, same cycle as the SRAM strobe
//   rvalid, rdata   read return, one cycle after the read grant, tagged by owner
//   CEN, GWEN, WEN  per-bank active-low macro controls
//   A, D            per-bank word address and write data
//   Q               per-bank read data, valid the cycle after CEN low
module dmem_port_arbiter #(
   parameter logic [31:0] BASE  = 32'h9000_0000,
   parameter logic [31:0] SIZE  = 32'h0000_0800,
   parameter int          ABITS = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [1:0]       we,
   input  logic [31:0]      addr  [0:1],
   input  logic [31:0]      wdata [0:1],
   input  logic [3:0]       wmask [0:1],
   output logic [1:0]       gnt,
   output logic [1:0]       rvalid,
   output logic [31:0]      rdata,
   output logic [3:0]       CEN,
   output logic [3:0]       GWEN,
   output logic [7:0]       WEN   [0:3],
   output logic [ABITS-1:0] A     [0:3],
   output logic [7:0]       D     [0:3],
   input  logic [7:0]       Q     [0:3]
);

   typedef enum logic {IDLE, RD_PEND} state_t;

   // 33-bit limit so BASE+SIZE cannot wrap
   localparam logic [32:0] LIMIT = {1'b0, BASE} + {1'b0, SIZE};

   state_t           state;
   logic             ptr;        // 1 = master 1 wins the next tie
   logic             rd_hit;     // pending read was in range
   logic [1:0]       rvalid_q;
   logic [ABITS-1:0] a_q [0:3];
   logic [7:0]       d_q [0:3];

   logic             sel;
   logic             granted;
   logic [31:0]      cur_addr;
   logic             cur_we;
   logic [31:0]      cur_wdata;
   logic [3:0]       cur_wmask;
   logic             in_range;
   logic [ABITS-1:0] word;
   logic             rd_grant;
   logic [3:0]       strobe;
   logic [3:0]       wr_strobe;

   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign sel       = gnt[1];
   assign granted   = |gnt;
   assign cur_addr  = addr[sel];
   assign cur_we    = we[sel];
   assign cur_wdata = wdata[sel];
   assign cur_wmask = wmask[sel];
   assign in_range  = (cur_addr >= BASE) && ({1'b0, cur_addr} < LIMIT);
   assign word      = cur_addr[ABITS+1:2];
   assign rd_grant  = granted && !cur_we;

   // A and D are only updated for banks actually strobed; otherwise they hold.
   always_comb begin
      strobe    = 4'b0000;
      wr_strobe = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         strobe[i]    = granted && in_range && (!cur_we || cur_wmask[i]);
         wr_strobe[i] = strobe[i] && cur_we;
         CEN[i]       = ~strobe[i];
         GWEN[i]      = ~wr_strobe[i];
         WEN[i]       = wr_strobe[i] ? 8'h00 : 8'hFF;
         A[i]         = strobe[i] ? word : a_q[i];
         D[i]         = wr_strobe[i] ? cur_wdata[8*i +: 8] : d_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         rd_hit   <= 1'b0;
         rvalid_q <= 2'b00;
         for (int i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            d_q[i] <= '0;
         end
      end else begin
         if (granted)
            ptr <= ~sel;
         for (int i = 0; i < 4; i++) begin
            if (strobe[i])
               a_q[i] <= word;
            if (wr_strobe[i])
               d_q[i] <= cur_wdata[8*i +: 8];
         end
         rd_hit   <= rd_grant && in_range;
         rvalid_q <= rd_grant ? gnt : 2'b00;
         case (state)
            IDLE:    if (rd_grant) state <= RD_PEND;
            RD_PEND: state <= rd_grant ? RD_PEND : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Gated by rst so a read pending when reset arrives never surfaces.
   assign rvalid = (state == RD_PEND && !rst) ? rvalid_q : 2'b00;
   assign rdata  = (state == RD_PEND && rd_hit && !rst) ? {Q[3], Q[2], Q[1], Q[0]} : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr  [0:1];
   logic [31:0] wdata [0:1];
   logic [3:0]  wmask [0:1];
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [31:0] rdata;
   logic [3:0]  CEN;
   logic [3:0]  GWEN;
   logic [7:0]  WEN [0:3];
   logic [8:0]  A   [0:3];
   logic [7:0]  D   [0:3];
   logic [7:0]  Q   [0:3];

   dmem_port_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .wmask(wmask), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .CEN(CEN),
      .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
   );

   always #5 clk = ~clk;

   // SRAM macro model
   logic [7:0] mem [0:3][0:511];
   logic       mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int b = 0; b < 4; b++)
            for (int w = 0; w < 512; w++)
               mem[b][w] <= 8'h00;
         for (int b = 0; b < 4; b++)
            Q[b] <= 8'h00;
         mem_init_done <= 1'b1;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (!CEN[b]) begin
               if (!GWEN[b])
                  mem[b][A[b]] <= (mem[b][A[b]] & WEN[b]) | (D[b] & ~WEN[b]);
               else
                  Q[b] <= mem[b][A[b]];
            end
         end
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   typedef struct {
      logic [1:0]  own;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q [$];
   exp_t cur_exp;

   logic [31:0] shadow [0:511];

   function automatic logic in_rng(input logic [31:0] a);
      return (a >= 32'h9000_0000) && (a < 32'h9000_0800);
   endfunction

   // Reference model of one granted access; reads are queued for the return check.
   task automatic expect_access(input logic [1:0] g);
      int          m;
      logic [31:0] a;
      logic [8:0]  w;
      exp_t        e;
      if (g == 2'b00) return;
      m = g[1] ? 1 : 0;
      a = addr[m];
      w = a[10:2];
      if (we[m]) begin
         if (in_rng(a))
            for (int l = 0; l < 4; l++)
               if (wmask[m][l]) shadow[w][8*l +: 8] = wdata[m][8*l +: 8];
      end else begin
         e.own  = g;
         e.data = in_rng(a) ? shadow[w] : 32'h0;
         exp_q.push_back(e);
      end
   endtask

   // Read-return scoreboard: every queued read must come back the next cycle.
   always @(posedge clk) begin
      #3;
      if (rst) begin
         exp_q.delete();
      end else if (mem_init_done) begin
         if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            chk("rvalid", {62'd0, rvalid}, {62'd0, cur_exp.own});
            chk("rdata", {32'd0, rdata}, {32'd0, cur_exp.data});
         end else begin
            chk("rvalid_idle", {62'd0, rvalid}, 64'd0);
            chk("rdata_idle", {32'd0, rdata}, 64'd0);
         end
      end
   end

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] wd;
      logic [3:0]  m;
      logic [1:0]  egnt;
      logic [3:0]  ecen;
      logic [3:0]  egwen;
      logic [8:0]  ea1;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] w,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] wd, input logic [3:0] m,
                               input logic [1:0] g, input logic [3:0] cen,
                               input logic [3:0] gw, input logic [8:0] ea);
      vec_t v;
      v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.wd = wd; v.m = m;
      v.egnt = g; v.ecen = cen; v.egwen = gw; v.ea1 = ea;
      return v;
   endfunction

   vec_t tv [0:16];

   task automatic drive(input logic [1:0] rq, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] wd, input logic [3:0] m);
      req = rq; we = w; addr[0] = a0; addr[1] = a1;
      wdata[0] = wd; wdata[1] = wd; wmask[0] = m; wmask[1] = m;
   endtask

   initial begin
      for (int w = 0; w < 512; w++) shadow[w] = 32'h0;
      //             req    we     addr0          addr1          wdata          mask   gnt    CEN      GWEN     A[1]
      tv[0]  = mk(2'b01, 2'b01, 32'h9000_0010, 32'h0,         32'hDEAD_BEEF, 4'hF, 2'b01, 4'b0000, 4'b0000, 9'd4);
      tv[1]  = mk(2'b01, 2'b00, 32'h9000_0010, 32'h0,         32'h0,         4'hF, 2'b01, 4'b0000, 4'b1111, 9'd4);
      tv[2]  = mk(2'b01, 2'b01, 32'h9000_0010, 32'h0,         32'h0000_AB00, 4'h2, 2'b01, 4'b1101, 4'b1101, 9'd4);
      tv[3]  = mk(2'b01, 2'b00, 32'h9000_0010, 32'h0,         32'h0,         4'hF, 2'b01, 4'b0000, 4'b1111, 9'd4);
      tv[4]  = mk(2'b10, 2'b10, 32'h0,         32'h9000_0014, 32'h1234_5678, 4'hF, 2'b10, 4'b0000, 4'b0000, 9'd5);
      tv[5]  = mk(2'b11, 2'b00, 32'h9000_0010, 32'h9000_0014, 32'h0,         4'hF, 2'b01, 4'b0000, 4'b1111, 9'd4);
      tv[6]  = mk(2'b11, 2'b00, 32'h9000_0010, 32'h9000_0014, 32'h0,         4'hF, 2'b10, 4'b0000, 4'b1111, 9'd5);
      tv[7]  = mk(2'b11, 2'b00, 32'h9000_0010, 32'h9000_0014, 32'h0,         4'hF, 2'b01, 4'b0000, 4'b1111, 9'd4);
      tv[8]  = mk(2'b11, 2'b00, 32'h9000_0010, 32'h9000_0014, 32'h0,         4'hF, 2'b10, 4'b0000, 4'b1111, 9'd5);
      tv[9]  = mk(2'b10, 2'b00, 32'h0,         32'h8000_0000, 32'h0,         4'hF, 2'b10, 4'b1111, 4'b1111, 9'd5);
      tv[10] = mk(2'b00, 2'b00, 32'h0,         32'h0,         32'h0,         4'hF, 2'b00, 4'b1111, 4'b1111, 9'd5);
      tv[11] = mk(2'b01, 2'b01, 32'h9000_0020, 32'h0,         32'hFFFF_FFFF, 4'h0, 2'b01, 4'b1111, 4'b1111, 9'd5);
      tv[12] = mk(2'b01, 2'b01, 32'h9000_07FC, 32'h0,         32'hCAFE_F00D, 4'hF, 2'b01, 4'b0000, 4'b0000, 9'h1FF);
      tv[13] = mk(2'b10, 2'b00, 32'h0,         32'h9000_07FC, 32'h0,         4'hF, 2'b10, 4'b0000, 4'b1111, 9'h1FF);
      tv[14] = mk(2'b01, 2'b01, 32'h9000_0800, 32'h0,         32'h5555_5555, 4'hF, 2'b01, 4'b1111, 4'b1111, 9'h1FF);
      tv[15] = mk(2'b10, 2'b00, 32'h0,         32'h9000_0000, 32'h0,         4'hF, 2'b10, 4'b0000, 4'b1111, 9'd0);
      tv[16] = mk(2'b00, 2'b00, 32'h0,         32'h0,         32'h0,         4'hF, 2'b00, 4'b1111, 4'b1111, 9'd0);

      // Reset held two cycles with both masters requesting
      rst = 1'b1;
      drive(2'b11, 2'b00, 32'h9000_0010, 32'h9000_0014, 32'h0, 4'hF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", {62'd0, gnt}, 64'd0);
      chk("rst_cen", {60'd0, CEN}, 64'hF);
      chk("rst_gwen", {60'd0, GWEN}, 64'hF);
      chk("rst_wen", {32'd0, WEN[3], WEN[2], WEN[1], WEN[0]}, 64'hFFFF_FFFF);
      chk("rst_rvalid", {62'd0, rvalid}, 64'd0);
      chk("rst_rdata", {32'd0, rdata}, 64'd0);
      chk("rst_a0", {55'd0, A[0]}, 64'd0);

      @(posedge clk); #1;
      rst = 1'b0;
      drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);

      for (int i = 0; i <= 16; i++) begin
         @(posedge clk); #1;
         drive(tv[i].req, tv[i].we, tv[i].a0, tv[i].a1, tv[i].wd, tv[i].m);
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i), {62'd0, gnt}, {62'd0, tv[i].egnt});
         chk($sformatf("v%0d_cen", i), {60'd0, CEN}, {60'd0, tv[i].ecen});
         chk($sformatf("v%0d_gwen", i), {60'd0, GWEN}, {60'd0, tv[i].egwen});
         chk($sformatf("v%0d_a1", i), {55'd0, A[1]}, {55'd0, tv[i].ea1});
         if (tv[i].egwen == 4'b0000)
            chk($sformatf("v%0d_d0", i), {56'd0, D[0]}, {56'd0, tv[i].wd[7:0]});
         expect_access(tv[i].egnt);
      end

      // Reset arriving while a read is pending
      @(posedge clk); #1;
      drive(2'b01, 2'b00, 32'h9000_0010, 32'h0, 32'h0, 4'hF);
      @(negedge clk);
      chk("mid_gnt", {62'd0, gnt}, 64'd1);
      expect_access(2'b01);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("mid_rvalid", {62'd0, rvalid}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(2'b11, 2'b00, 32'h9000_0010, 32'h9000_0014, 32'h0, 4'hF);
      @(negedge clk);
      chk("post_rst_gnt", {62'd0, gnt}, 64'd1);
      expect_access(gnt == 2'b01 ? 2'b01 : 2'b00);
      @(posedge clk); #1;
      drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
